// File: rtl/control_sequencer_if.sv
// Bus between the SAP-1 instruction register side and the control sequencer.
// The sequencer uses the slave modport; the upstream driver uses master.
interface control_sequencer_if;
  // No handshake: run is a level-sensitive enable sampled on every falling
  // clk edge; opcode is live, and con/t_state/hlt are valid at all times.
  logic        run;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        hlt;

  modport master (output run, output opcode, input con, input t_state, input hlt);
  modport slave  (input run, input opcode, output con, output t_state, output hlt);
endinterface

// File: rtl/control_sequencer.sv
// SAP-1 controller/sequencer: 6-state one-hot ring with {T-state, opcode} decode.
// Define SEQ_EARLY_END_EN to end LDA/OUT/unknown instructions early.
module control_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input logic               clk,
  input logic               reset,
  control_sequencer_if.slave bus
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam logic [11:0] CON_NOP = 12'h3E3;

  logic [5:0]  t_state_q;
  logic [5:0]  t_state_d;
  logic        hlt_q;
  logic        halt_now;
  logic        op_known;
  logic [11:0] con;

  assign op_known = (bus.opcode == OP_LDA) || (bus.opcode == OP_ADD) ||
                    (bus.opcode == OP_SUB) || (bus.opcode == OP_OUT) ||
                    (bus.opcode == OP_HLT);

  assign halt_now = (t_state_q == T3) && (bus.opcode == OP_HLT);

  // Any code outside the six legal ones falls back to T1, so the ring can
  // never settle on a non-one-hot value.
  always_comb begin
    t_state_d = T1;
    case (t_state_q)
      T1: t_state_d = T2;
      T2: t_state_d = T3;
      T3: begin
`ifdef SEQ_EARLY_END_EN
        t_state_d = op_known ? T4 : T1;
`else
        t_state_d = T4;
`endif
      end
      T4: begin
`ifdef SEQ_EARLY_END_EN
        t_state_d = (bus.opcode == OP_OUT) ? T1 : T5;
`else
        t_state_d = T5;
`endif
      end
      T5: begin
`ifdef SEQ_EARLY_END_EN
        t_state_d = (bus.opcode == OP_LDA) ? T1 : T6;
`else
        t_state_d = T6;
`endif
      end
      T6:      t_state_d = T1;
      default: t_state_d = T1;
    endcase
  end

  // The sequencer advances on the falling edge so control lines are settled
  // before the datapath registers load on the following rising edge.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      t_state_q <= T1;
      hlt_q     <= 1'b0;
    end else if (bus.run && !hlt_q) begin
      t_state_q <= t_state_d;
      if (halt_now) hlt_q <= 1'b1;
    end
  end

  always_comb begin
    con = CON_NOP;
    if (!hlt_q) begin
      case (t_state_q)
        T1: con = 12'h5E3;
        T2: con = 12'hBE3;
        T3: con = 12'h263;
        T4: begin
          if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB)
            con = 12'h1A3;
          else if (bus.opcode == OP_OUT)
            con = 12'h3F2;
        end
        T5: begin
          if (bus.opcode == OP_LDA)
            con = 12'h2C3;
          else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB)
            con = 12'h2E1;
        end
        T6: begin
          if (bus.opcode == OP_ADD)
            con = 12'h3C7;
          else if (bus.opcode == OP_SUB)
            con = 12'h3CF;
        end
        default: con = CON_NOP;
      endcase
    end
  end

  assign bus.con     = con;
  assign bus.t_state = t_state_q;
  assign bus.hlt     = hlt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed steps plus a random
// phase, checked against a step-number reference model.
module tb_control_sequencer;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

`ifdef SEQ_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic reset;
  control_sequencer_if bus();

  control_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_step;  // 1..6
  bit          m_hlt;
  int          checks;
  int          errors;
  logic [11:0] exp_q[$];

  function automatic bool_known(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

  function automatic int inst_len(input logic [3:0] op);
    if (!EARLY) return 6;
    if (op == OP_LDA) return 5;
    if (op == OP_OUT) return 4;
    if (!bool_known(op)) return 3;
    return 6;
  endfunction

  function automatic logic [11:0] exp_con(input int step, input logic [3:0] op, input bit h);
    if (h) return 12'h3E3;
    case (step)
      1: return 12'h5E3;
      2: return 12'hBE3;
      3: return 12'h263;
      default: ;
    endcase
    if (op == OP_LDA) begin
      if (step == 4) return 12'h1A3;
      if (step == 5) return 12'h2C3;
      return 12'h3E3;
    end
    if (op == OP_ADD || op == OP_SUB) begin
      if (step == 4) return 12'h1A3;
      if (step == 5) return 12'h2E1;
      return (op == OP_ADD) ? 12'h3C7 : 12'h3CF;
    end
    if (op == OP_OUT && step == 4) return 12'h3F2;
    return 12'h3E3;
  endfunction

  function automatic logic [5:0] exp_t(input int step);
    logic [5:0] one;
    one = 6'b000001;
    return one << (step - 1);
  endfunction

  task automatic model_reset();
    m_step = 1;
    m_hlt  = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag);
    logic [11:0] e_con;
    logic [5:0]  e_t;
    exp_q.push_back(exp_con(m_step, bus.opcode, m_hlt));
    e_con = exp_q.pop_front();
    e_t   = exp_t(m_step);
    checks++;
    assert (bus.t_state === e_t) else begin
      errors++;
      $error("FAIL %s t_state observed=%b expected=%b", tag, bus.t_state, e_t);
    end
    checks++;
    assert (bus.con === e_con) else begin
      errors++;
      $error("FAIL %s con observed=%h expected=%h", tag, bus.con, e_con);
    end
    checks++;
    assert (bus.hlt === m_hlt) else begin
      errors++;
      $error("FAIL %s hlt observed=%b expected=%b", tag, bus.hlt, m_hlt);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Model advance uses the inputs present at the coming falling edge.
  task automatic tick(input string tag);
    if (bus.run && !m_hlt) begin
      if (m_step == 3 && bus.opcode == OP_HLT) begin
        m_step = 4;
        m_hlt  = 1'b1;
      end else if (m_step == inst_len(bus.opcode) || m_step == 6) begin
        m_step = 1;
      end else begin
        m_step++;
      end
    end
    @(negedge clk);
    #1;
    check(tag);
  endtask

  task automatic set_op(input logic [3:0] op, input string tag);
    bus.opcode = op;
    #1;
    check(tag);
  endtask

  task automatic go_t1();
    for (int i = 0; i < 8 && m_step != 1; i++) tick("go_t1");
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check(tag);
    reset = 1'b1;
  endtask

  task automatic measure_len(input logic [3:0] op);
    int cnt;
    go_t1();
    bus.opcode = op;
    cnt = 0;
    do begin
      tick("len");
      cnt++;
    end while (bus.t_state !== 6'b000001 && cnt < 12);
    checks++;
    assert (cnt === inst_len(op)) else begin
      errors++;
      $error("FAIL len op=%h observed=%0d expected=%0d", op, cnt, inst_len(op));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    bus.run    = 1'b1;
    bus.opcode = OP_LDA;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset");
    reset = 1'b1;

    // LDA: full instruction and wrap back to T1
    for (int i = 0; i < 7; i++) tick("lda");

    // ADD then SUB, random opcode noise during fetch of SUB
    go_t1();
    bus.opcode = OP_ADD;
    for (int i = 0; i < 6; i++) tick("add");
    set_op(4'($urandom_range(0, 15)), "fetch_noise_t1");
    tick("sub_t2");
    set_op(4'($urandom_range(0, 15)), "fetch_noise_t2");
    tick("sub_t3");
    set_op(4'($urandom_range(0, 15)), "fetch_noise_t3");
    bus.opcode = OP_SUB;
    for (int i = 0; i < 4; i++) tick("sub");

    // run low at T3 holds the ring
    go_t1();
    bus.opcode = OP_LDA;
    tick("run_t2");
    tick("run_t3");
    bus.run = 1'b0;
    for (int i = 0; i < 4; i++) tick("run_hold");
    bus.run = 1'b1;
    tick("run_resume");

    // HLT freezes at T4 until reset
    go_t1();
    bus.opcode = OP_HLT;
    for (int i = 0; i < 3; i++) tick("hlt_enter");
    for (int i = 0; i < 10; i++) tick("hlt_hold");
    async_reset("hlt_reset");

    // asynchronous reset at T5 of ADD
    bus.opcode = OP_ADD;
    for (int i = 0; i < 4; i++) tick("add_to_t5");
    async_reset("mid_reset");

    // instruction lengths
    measure_len(OP_OUT);
    measure_len(OP_LDA);
    measure_len(4'h7);
    measure_len(OP_ADD);

    // random phase: live opcode and run changes
    for (int i = 0; i < 200; i++) begin
      bus.opcode = 4'($urandom_range(0, 14));
      bus.run    = ($urandom_range(0, 3) != 0);
      tick("random");
    end
    bus.run = 1'b1;
    async_reset("final_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- SAP-1 controller/sequencer; sits directly downstream of the instruction register.
- Consumes the 4-bit opcode nibble from the IR.
- A 6-state one-hot ring counter (T1..T6) steps through fetch and execute.
- Decodes {T-state, opcode} into the 12-bit control word that drives PC, MAR, RAM, IR, accumulator, ALU, B and output registers; also raises the halt flag.

Parameters:
- OP_LDA, 4'h0, load-accumulator opcode
- OP_ADD, 4'h1, add opcode
- OP_SUB, 4'h2, subtract opcode
- OP_OUT, 4'hE, output opcode
- OP_HLT, 4'hF, halt opcode

Ports:
- clk  input  1  system clock; sequencer state changes on the falling edge
- reset  input  1  asynchronous, active-low reset
- run  input  1  active-high; when low the ring counter holds its current state
- opcode  input  4  instruction nibble from the IR control field
- con  output  12  control word: [11]Cp [10]Ep [9]nLm [8]nCE [7]nLi [6]nEi [5]nLa [4]Ea [3]Su [2]Eu [1]nLb [0]nLo
- t_state  output  6  one-hot ring state; bit0 = T1 ... bit5 = T6
- hlt  output  1  halt flag, high while halted

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset state: t_state = 6'b000001 (T1), hlt = 0. Since con decodes from state, con = 12'h5E3 while reset is held.
- Reset dominates run and any clock edge. Reset asserted mid-instruction returns to T1 immediately; no partial-cycle completion.
- State update on each falling clk edge with run = 1 and hlt = 0: ring rotates T1→T2→…→T6→T1.
- State hold: with run = 0 or hlt = 1, t_state holds.
- con decode: combinational from t_state and opcode, no extra latency. NOP word = 12'h3E3 (all active-low bits high, active-high bits low).
- Fetch, opcode-independent:
  - T1 = 12'h5E3 (Ep, Lm)
  - T2 = 12'hBE3 (Cp)
  - T3 = 12'h263 (CE, Li)
- LDA: T4 = 12'h1A3 (Lm, Ei); T5 = 12'h2C3 (CE, La); T6 = 12'h3E3.
- ADD: T4 = 12'h1A3; T5 = 12'h2E1 (CE, Lb); T6 = 12'h3C7 (Eu, La).
- SUB: same as ADD except T6 = 12'h3CF (Su, Eu, La).
- OUT: T4 = 12'h3F2 (Ea, Lo); T5 and T6 = 12'h3E3.
- HLT:
  - The falling edge that leaves T3 with opcode = OP_HLT loads T4 and sets hlt = 1 on the same edge.
  - Counter then freezes at T4; con = 12'h3E3 while halted.
  - Only reset clears hlt.
- Unknown opcode: T4..T6 = 12'h3E3; no halt.
- Opcode sampling: decode uses the live opcode input. The IR is stable from T4 onward because Li pulses only in T3. Opcode changes during T1..T3 do not affect con.
- Invariant: t_state is always exactly one-hot. The implementation must not be able to reach any other code.

Optional Feature:
- Macro SEQ_EARLY_END_EN, variable-length instructions.
- With the macro defined, the ring returns to T1 instead of stepping into trailing NOP states:
  - LDA: T5→T1
  - OUT: T4→T1
  - unknown opcode: T3→T1
  - ADD/SUB still use all six states
  - HLT behaviour unchanged
- Without the macro, every instruction takes exactly 6 T-states.

Test Plan:
- Reset low for 2 cycles, release, run = 1, opcode = 4'h0 → t_state = 000001, con = 5E3; following falling edges give BE3, 263, 1A3, 2C3, 3E3, then back to 5E3.
- ADD then SUB (opcode 4'h1, then 4'h2 from T4 of the second instruction) → T4..T6 words 1A3/2E1/3C7, then 1A3/2E1/3CF; ring wraps T6→T1 with no bubble.
- opcode = 4'hF → hlt rises on the edge entering T4; t_state stays 001000 and con = 3E3 for 10 further edges.
  - Then pulse reset low asynchronously (no clock edge) → t_state = 000001 and hlt = 0 immediately.
- run = 0 at T3 for 4 edges → t_state remains 000100, con = 263; run = 1 → next edge gives T4.
- Reset asserted between clock edges at T5 of ADD → t_state = 000001 and con = 5E3 before the next edge.
  - Random opcode toggling during T1..T3 → con matches fetch words exactly.
- With SEQ_EARLY_END_EN: OUT takes 4 edges per instruction, LDA 5, opcode 4'h7 takes 3, ADD 6; without the macro all take 6.
